// File: rtl/multicycle_sequencer.sv
// Multicycle RV64 sequencer: one FSM stepping each instruction through
// FETCH/DECODE/EXEC/MEM/WB, driving datapath selects and write enables,
// with a data-memory ready handshake, wait timeout, halt state and a
// retired-instruction counter.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             flag,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic [1:0]       aluop,
  output logic             mux1,
  output logic [1:0]       mux2,
  output logic             mux4,
  output logic             pc_sel,
  output logic             we_ir,
  output logic             we_pc,
  output logic             we_reg,
  output logic             we_mem,
  output logic             mem_req,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_HALT   = 4'd6
  } state_t;

  state_t              r_state;
  logic [6:0]          r_op;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
  logic [CNT_W-1:0]    r_retired;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_SD) ||
           (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // Datapath controls decoded from the current state and latched opcode;
  // only the branch PC select and the SD completion strobe look at inputs.
  always_comb begin
    aluop   = 2'b00;
    mux1    = 1'b0;
    mux2    = 2'b00;
    mux4    = 1'b0;
    pc_sel  = 1'b0;
    we_ir   = 1'b0;
    we_pc   = 1'b0;
    we_reg  = 1'b0;
    we_mem  = 1'b0;
    mem_req = 1'b0;
    case (r_state)
      S_FETCH: we_ir = 1'b1;
      S_EXEC: begin
        case (r_op)
          OP_R:         aluop = 2'b10;
          OP_I:         begin aluop = 2'b11; mux1 = 1'b1; end
          OP_LD, OP_SD: mux1 = 1'b1;
          OP_BR:        begin aluop = 2'b01; we_pc = 1'b1; pc_sel = flag; end
          OP_JALR:      begin mux4 = 1'b1; mux1 = 1'b1; end
          default:      ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mux1    = 1'b1;
        if (r_op == OP_SD) begin
          we_mem = 1'b1;
          we_pc  = mem_ready;
        end
      end
      S_WB: begin
        we_reg = 1'b1;
        we_pc  = 1'b1;
        case (r_op)
          OP_R:    begin mux2 = 2'b01; aluop = 2'b10; end
          OP_I:    begin mux2 = 2'b01; aluop = 2'b11; mux1 = 1'b1; end
          OP_JAL:  begin mux2 = 2'b10; pc_sel = 1'b1; end
          OP_JALR: begin mux2 = 2'b10; pc_sel = 1'b1; mux4 = 1'b1; end
          default: mux2 = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  // Status outputs mirror the registered state.
  always_comb begin
    state   = r_state;
    busy    = (r_state != S_IDLE) && (r_state != S_HALT);
    halted  = (r_state == S_HALT);
    err     = r_err;
    retired = r_retired;
  end

  // Sequencer state, opcode latch, memory wait counter, error and retire count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= 7'd0;
      r_wait    <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      if (we_pc) r_retired <= r_retired + 1'b1;
      case (r_state)
        S_IDLE:  if (start) r_state <= S_FETCH;
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_op <= opcode;
          if (opcode == OP_SYS) begin
            r_state <= S_HALT;
          end else if (!is_legal(opcode)) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == OP_BR) begin
            r_state <= S_FETCH;
          end else if ((r_op == OP_LD) || (r_op == OP_SD)) begin
            r_state <= S_MEM;
            r_wait  <= '0;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (r_op == OP_LD) ? S_WB : S_FETCH;
          end else begin
            r_wait <= r_wait + 1'b1;
            // Timeout abandons the access: no write-back, PC left untouched.
            if (r_wait == WAIT_LAST) begin
              r_state <= S_HALT;
              r_err   <= 1'b1;
            end
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: each instruction is run as a
// transaction and summarized (cycle count, strobe counts, selects seen at
// the strobes), then compared with a per-instruction-class model.
module tb_multicycle_sequencer;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_SYS = 7, K_ILL = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             flag = 1'b0;
  logic             mem_ready = 1'b0;
  logic [3:0]       state;
  logic [1:0]       aluop;
  logic             mux1;
  logic [1:0]       mux2;
  logic             mux4;
  logic             pc_sel;
  logic             we_ir;
  logic             we_pc;
  logic             we_reg;
  logic             we_mem;
  logic             mem_req;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  int      n_chk = 0;
  int      n_err = 0;
  longint  exp_ret = 0;
  logic    exp_err = 1'b0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .flag(flag),
    .mem_ready(mem_ready), .state(state), .aluop(aluop), .mux1(mux1),
    .mux2(mux2), .mux4(mux4), .pc_sel(pc_sel), .we_ir(we_ir), .we_pc(we_pc),
    .we_reg(we_reg), .we_mem(we_mem), .mem_req(mem_req), .busy(busy),
    .halted(halted), .err(err), .retired(retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_SD:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_SYS:   return 7'b1110011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    for (int k = K_R; k <= K_SYS; k++)
      if (op == op_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] ctl_vec();
    return {we_ir, we_pc, we_reg, we_mem, mem_req, pc_sel, mux1, mux4, aluop, mux2};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_ctl", ctl_vec(), 0);
    check("rst_retired", retired, 0);
    check("rst_err", err, 0);
    check("rst_busy_halt", {busy, halted}, 0);
    reset = 1'b1;
    exp_ret = 0;
    exp_err = 1'b0;
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH.
  task automatic begin_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_fetch", state, 1);
  endtask

  // Runs one instruction from FETCH; w = mem_ready low cycles (>=MEM_TIMEOUT means stuck).
  task automatic run_instr(input int k, input logic [6:0] op, input logic f, input int w);
    int cyc = 0, mcnt = 0, n_reg = 0, n_mem = 0, n_req = 0, n_ir = 0, n_pc = 0;
    int n_bad = 0, n_nb = 0;
    logic [1:0] m2 = 2'b00, alu = 2'b00;
    logic ps = 1'b0, m1 = 1'b0, m4 = 1'b0;
    bit done = 1'b0;
    logic [3:0] st_end = 4'd0;
    bit tmo = (w >= MEM_TIMEOUT);
    int e_cyc = 4, e_ret = 1, e_reg = 0, e_mem = 0, e_req = 0, e_pc = 0;
    logic [3:0] e_end = 4'd1;
    logic e_err = 1'b0, e_ps = 1'b0, e_m1 = 1'b0, e_m4 = 1'b0;
    logic [1:0] e_m2 = 2'b00, e_alu = 2'b00;

    case (k)
      K_R:  begin e_reg = 1; e_m2 = 2'b01; e_alu = 2'b10; e_pc = 1; end
      K_I:  begin e_reg = 1; e_m2 = 2'b01; e_alu = 2'b11; e_m1 = 1'b1; e_pc = 1; end
      K_LD: begin
        e_m1 = 1'b1;
        if (tmo) begin
          e_cyc = 3 + MEM_TIMEOUT; e_end = 4'd6; e_err = 1'b1; e_ret = 0; e_req = MEM_TIMEOUT;
        end else begin
          e_cyc = 5 + w; e_req = w + 1; e_reg = 1; e_m2 = 2'b00; e_pc = 1;
        end
      end
      K_SD: begin
        e_m1 = 1'b1;
        if (tmo) begin
          e_cyc = 3 + MEM_TIMEOUT; e_end = 4'd6; e_err = 1'b1; e_ret = 0;
          e_req = MEM_TIMEOUT; e_mem = MEM_TIMEOUT;
        end else begin
          e_cyc = 4 + w; e_req = w + 1; e_mem = w + 1; e_pc = 1;
        end
      end
      K_BR:   begin e_cyc = 3; e_alu = 2'b01; e_pc = 1; e_ps = f; end
      K_JAL:  begin e_reg = 1; e_m2 = 2'b10; e_pc = 1; e_ps = 1'b1; end
      K_JALR: begin e_reg = 1; e_m2 = 2'b10; e_pc = 1; e_ps = 1'b1; e_m4 = 1'b1; e_m1 = 1'b1; end
      K_SYS:  begin e_cyc = 2; e_end = 4'd6; e_ret = 0; end
      default: begin e_cyc = 2; e_end = 4'd6; e_ret = 0; e_err = 1'b1; end
    endcase

    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (state == 4'd1 || state == 4'd6) begin
          done = 1'b1;
          st_end = state;
        end
      end
      if (!done) begin
        opcode = op;
        flag = f;
        mem_ready = (state == 4'd4) && (mcnt >= w);
        #1;
        cyc++;
        if (int'(we_reg) + int'(we_mem) + int'(we_ir) > 1) n_bad++;
        if (busy !== 1'b1) n_nb++;
        if (we_reg) begin n_reg++; m2 = mux2; end
        if (we_mem) n_mem++;
        if (mem_req) n_req++;
        if (we_ir) n_ir++;
        if (we_pc) begin n_pc++; ps = pc_sel; end
        if (state == 4'd3) begin alu = aluop; m1 = mux1; m4 = mux4; end
        if (state == 4'd4) mcnt++;
      end
    end
    if (!done) check("cycle_bound", 0, 1);

    exp_ret += e_ret;
    exp_err |= e_err;
    check("cycles", cyc, e_cyc);
    check("end_state", st_end, e_end);
    check("retired", retired, exp_ret & 64'hFFFF_FFFF);
    check("err", err, exp_err);
    check("halted", halted, e_end == 4'd6);
    check("we_ir_cnt", n_ir, 1);
    check("we_reg_cnt", n_reg, e_reg);
    check("we_mem_cnt", n_mem, e_mem);
    check("mem_req_cnt", n_req, e_req);
    check("we_pc_cnt", n_pc, e_pc);
    check("pc_sel_at_we_pc", ps, e_ps);
    check("mux2_at_we_reg", m2, e_m2);
    check("exec_aluop", alu, e_alu);
    check("exec_mux1_mux4", {m1, m4}, {e_m1, e_m4});
    check("we_onehot_bad", n_bad, 0);
    check("busy_low", n_nb, 0);

    if (e_end == 4'd6) begin
      check("halt_ctl", ctl_vec(), 0);
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("halt_ignores_start", state, 6);
      start = 1'b0;
    end
  endtask

  task automatic do_instr(input int k, input logic f, input int w);
    logic [6:0] op;
    op = op_of(k);
    if (k == K_ILL) begin
      op = 7'($urandom);
      while (is_known(op)) op = 7'($urandom);
    end
    run_instr(k, op, f, w);
    if (halted === 1'b1) begin
      do_reset();
      begin_run();
    end
  endtask

  initial begin
    #2;
    do_reset();
    begin_run();

    do_instr(K_R, 1'b0, 0);
    do_instr(K_I, 1'b0, 0);
    do_instr(K_BR, 1'b1, 0);
    do_instr(K_BR, 1'b0, 0);
    do_instr(K_LD, 1'b0, 3);
    do_instr(K_SD, 1'b0, 0);
    do_instr(K_SD, 1'b1, 2);
    do_instr(K_JAL, 1'b0, 0);
    do_instr(K_JALR, 1'b0, 0);
    do_instr(K_LD, 1'b0, 0);

    // Abort an R instruction in EXEC with an asynchronous reset.
    opcode = op_of(K_R);
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_exec", state, 3);
    reset = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_ctl", ctl_vec(), 0);
    check("abort_retired", retired, 0);
    exp_ret = 0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_restart_fetch", state, 1);
    start = 1'b0;
    @(negedge clk);
    do_instr(K_R, 1'b0, 0);

    run_instr(K_ILL, 7'b1111111, 1'b0, 0);
    do_reset();
    begin_run();
    do_instr(K_LD, 1'b0, 99);
    do_instr(K_SYS, 1'b0, 0);
    do_instr(K_SD, 1'b0, 99);
    do_instr(K_ILL, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5)       do_instr(K_SYS, 1'b0, 0);
      else if (r < 10) do_instr(K_ILL, 1'b0, 0);
      else if (r < 14) do_instr((r < 12) ? K_LD : K_SD, 1'b0, 99);
      else do_instr(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
